hotspot_stencil_pipe: RTL and testbench
=======================================

HOTSPOT_STENCIL_PIPE -- requirements
Module: hotspot_stencil_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, total signed fixed-point word width.
REQ-002 SHALL have parameter INT_WIDTH, default 10, integer bits including sign.
REQ-003 SHALL have parameter FLOAT_WIDTH, default 22, fraction bits; DATA_WIDTH != INT_WIDTH+FLOAT_WIDTH SHALL be a fatal elaboration error.
REQ-004 SHALL have parameter CELLS_PER_ROW, default 64, number of results per row (1..65535).
REQ-005 SHALL have the following ports, clock and reset first:
aclk  in  1  single clock, rising edge
axi_resetn  in  1  asynchronous active-low reset
s_axis_temp_data  in  DATA_WIDTH  temperature beat, order c,n,s,e,w
s_axis_temp_valid  in  1  temp beat valid
s_axis_temp_ready  out  1  temp beat accepted when valid&ready
s_axis_power_data  in  DATA_WIDTH  cell power
s_axis_power_valid  in  1  power valid
s_axis_power_ready  out  1  power accepted when valid&ready
m_axis_temp_data  out  DATA_WIDTH  updated cell temperature
m_axis_temp_valid  out  1  result valid
m_axis_temp_ready  in  1  downstream ready
m_axis_temp_last  out  1  high on final result of a row
cns, cwe, cc, Cap_1, c_amb  in  DATA_WIDTH each  coefficients, sampled on entry to S1, static otherwise

Function
REQ-006 States: COLLECT, S1, S2, OUT.
REQ-007 COLLECT: s_axis_temp_ready=1 while beat count<5; s_axis_power_ready=1 while cell power not yet captured; temp beats stored by count 0..4 as c,n,s,e,w; both streams independent, either may complete first.
REQ-008 COLLECT->S1 on the edge where 5th temp beat and power are both held (including simultaneous final handshakes).
REQ-009 S1: d_ns=(n+s-2c), d_we=(e+w-2c), d_amb=(c_amb-c) in DATA_WIDTH+2 bits; each multiplied by cns, cwe, cc respectively; sum with power -> acc.
REQ-010 S2: result = c + fx_mul(Cap_1, acc); S2->OUT unconditionally.
REQ-011 fx_mul: full signed product, arithmetic shift right by FLOAT_WIDTH (truncate toward -inf); all intermediate sums kept at full width; narrowing to DATA_WIDTH only at final result per REQ-021.
REQ-012 Latency: m_axis_temp_valid high on the 3rd rising edge after the completing input handshake.
REQ-013 OUT: m_axis_temp_valid=1, data and last stable until m_axis_temp_ready; on handshake -> COLLECT next cycle with beat count 0, power flag cleared.
REQ-014 Both s_axis ready outputs SHALL be 0 in S1, S2, OUT; one cell in flight.
REQ-015 Row counter increments per output handshake; m_axis_temp_last=1 when counter==CELLS_PER_ROW-1; counter wraps to 0 after that handshake.
REQ-016 Beats with valid low SHALL not advance counters; ready SHALL not depend combinationally on valid.

Reset
REQ-017 axi_resetn low SHALL asynchronously force state COLLECT, beat count 0, power flag 0, row counter 0, all stored operands 0.
REQ-018 During reset: s_axis_temp_ready=0, s_axis_power_ready=0, m_axis_temp_valid=0, m_axis_temp_last=0, m_axis_temp_data=0.
REQ-019 Reset mid-cell or mid-pipeline SHALL discard the partial cell; no stale result SHALL appear after release.
REQ-020 Ready outputs SHALL assert on the first rising edge after reset release.

Configuration
REQ-021 Macro HOTSPOT_STENCIL_SAT_EN: defined -> final result clamped to most positive/negative DATA_WIDTH value on overflow; undefined -> low DATA_WIDTH bits taken (two's-complement wrap).

Verification (Q10.22, defaults)
REQ-022 c=n=s=e=w=8.0 (0x02000000), power=0, c_amb=8.0, any coefficients -> result 0x02000000, latency 3 cycles.
REQ-023 all temps 0, power=1.0 (0x00400000), Cap_1=2.0 (0x00800000), c_amb=0 -> result 0x00800000.
REQ-024 c=n=s=e=w=511.0 (0x7FC00000), c_amb=511.0, power=1.0, Cap_1=2.0 -> 0x7FFFFFFF with SAT_EN, 0x80400000 without.
REQ-025 m_axis_temp_ready low 10 cycles while in OUT -> valid, data, last held; both input readys 0; no input beat consumed.
REQ-026 Reset asserted after 3 temp beats, then full cell of REQ-023 -> result 0x00800000 only; CELLS_PER_ROW=4, 9 cells -> last high on results 4 and 8 only.

Source files
------------

// File: rtl/hotspot_stencil_pipe.sv
// hotspot_stencil_pipe
//   Single-cell HotSpot thermal stencil update in signed fixed point.
//   The block collects five temperature beats (c, n, s, e, w) and one
//   power value, then computes
//     acc    = fx(cns*(n+s-2c)) + fx(cwe*(e+w-2c)) + fx(cc*(c_amb-c)) + power
//     result = c + fx(Cap_1*acc)
//   where fx() is a full signed product shifted right by FLOAT_WIDTH.
//   Exactly one cell is in flight at a time.
//
// Ports
//   aclk, axi_resetn                 clock, asynchronous active-low reset
//   s_axis_temp_*                    temperature beats, order c,n,s,e,w
//   s_axis_power_*                   cell power, one value per cell
//   m_axis_temp_*                    updated temperature, last marks row end
//   cns, cwe, cc, Cap_1, c_amb       coefficients, captured on entry to S1
//
// Build option
//   HOTSPOT_STENCIL_SAT_EN  defined: clamp result to the DATA_WIDTH range
//                           undefined: keep low DATA_WIDTH bits (wrap)
module hotspot_stencil_pipe #(
    parameter int DATA_WIDTH    = 32,
    parameter int INT_WIDTH     = 10,
    parameter int FLOAT_WIDTH   = 22,
    parameter int CELLS_PER_ROW = 64
) (
    input  logic                  aclk,
    input  logic                  axi_resetn,
    input  logic [DATA_WIDTH-1:0] s_axis_temp_data,
    input  logic                  s_axis_temp_valid,
    output logic                  s_axis_temp_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_power_data,
    input  logic                  s_axis_power_valid,
    output logic                  s_axis_power_ready,
    output logic [DATA_WIDTH-1:0] m_axis_temp_data,
    output logic                  m_axis_temp_valid,
    input  logic                  m_axis_temp_ready,
    output logic                  m_axis_temp_last,
    input  logic [DATA_WIDTH-1:0] cns,
    input  logic [DATA_WIDTH-1:0] cwe,
    input  logic [DATA_WIDTH-1:0] cc,
    input  logic [DATA_WIDTH-1:0] Cap_1,
    input  logic [DATA_WIDTH-1:0] c_amb
);

    localparam int DW = DATA_WIDTH;
    localparam int FW = FLOAT_WIDTH;
    localparam int D2 = DW + 2;     // stencil differences
    localparam int PW = D2 + DW;    // coefficient * difference
    localparam int AW = PW + 2;     // sum of three terms plus power
    localparam int MW = AW + DW;    // Cap_1 * acc
    localparam int RW = MW + 1;     // c + scaled acc

    generate
        if (DATA_WIDTH != INT_WIDTH + FLOAT_WIDTH) begin : g_bad_width
            $fatal(1, "hotspot_stencil_pipe: DATA_WIDTH must equal INT_WIDTH + FLOAT_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {COLLECT, S1, S2, OUT} state_t;

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic                  r_pwr_held;
    logic [15:0]           r_row;
    logic                  r_temp_ready;
    logic                  r_pwr_ready;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DW-1:0]         r_out_data;
    logic signed [DW-1:0]  r_c, r_n, r_s, r_e, r_w, r_power;
    logic signed [DW-1:0]  r_cns, r_cwe, r_cc, r_cap, r_camb;
    logic signed [AW-1:0]  r_acc;

    logic                  w_temp_hs, w_pwr_hs, w_temp_done, w_pwr_done;
    logic [2:0]            w_cnt_next;
    logic signed [D2-1:0]  w_d_ns, w_d_we, w_d_amb;
    logic signed [PW-1:0]  w_p_ns, w_p_we, w_p_amb;
    logic signed [PW-1:0]  w_f_ns, w_f_we, w_f_amb;
    logic signed [AW-1:0]  w_acc;
    logic signed [MW-1:0]  w_m, w_f_m;
    logic signed [RW-1:0]  w_sum;
    logic [DW-1:0]         w_res;
`ifdef HOTSPOT_STENCIL_SAT_EN
    logic signed [DW-1:0]  w_trunc;
`endif

    // Readies are registered, so handshakes can only occur in COLLECT.
    always_comb begin
        w_temp_hs   = s_axis_temp_valid & r_temp_ready;
        w_pwr_hs    = s_axis_power_valid & r_pwr_ready;
        w_cnt_next  = w_temp_hs ? r_cnt + 3'd1 : r_cnt;
        w_temp_done = (w_cnt_next == 3'd5);
        w_pwr_done  = r_pwr_held | w_pwr_hs;
    end

    // Datapath: every stage is widened so no intermediate can overflow.
    always_comb begin
        w_d_ns  = D2'(r_n) + D2'(r_s) - (D2'(r_c) <<< 1);
        w_d_we  = D2'(r_e) + D2'(r_w) - (D2'(r_c) <<< 1);
        w_d_amb = D2'(r_camb) - D2'(r_c);
        w_p_ns  = PW'(w_d_ns)  * PW'(r_cns);
        w_p_we  = PW'(w_d_we)  * PW'(r_cwe);
        w_p_amb = PW'(w_d_amb) * PW'(r_cc);
        w_f_ns  = w_p_ns  >>> FW;
        w_f_we  = w_p_we  >>> FW;
        w_f_amb = w_p_amb >>> FW;
        w_acc   = AW'(w_f_ns) + AW'(w_f_we) + AW'(w_f_amb) + AW'(r_power);
        w_m     = MW'(r_cap) * MW'(r_acc);
        w_f_m   = w_m >>> FW;
        w_sum   = RW'(w_f_m) + RW'(r_c);
`ifdef HOTSPOT_STENCIL_SAT_EN
        w_trunc = DW'(w_sum);
        if (RW'(w_trunc) != w_sum)
            w_res = w_sum[RW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            w_res = w_trunc;
`else
        w_res = DW'(w_sum);
`endif
    end

    always_ff @(posedge aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state      <= COLLECT;
            r_cnt        <= '0;
            r_pwr_held   <= 1'b0;
            r_row        <= '0;
            r_temp_ready <= 1'b0;
            r_pwr_ready  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            r_c          <= '0;
            r_n          <= '0;
            r_s          <= '0;
            r_e          <= '0;
            r_w          <= '0;
            r_power      <= '0;
            r_cns        <= '0;
            r_cwe        <= '0;
            r_cc         <= '0;
            r_cap        <= '0;
            r_camb       <= '0;
            r_acc        <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_temp_hs) begin
                        case (r_cnt)
                            3'd0:    r_c <= s_axis_temp_data;
                            3'd1:    r_n <= s_axis_temp_data;
                            3'd2:    r_s <= s_axis_temp_data;
                            3'd3:    r_e <= s_axis_temp_data;
                            3'd4:    r_w <= s_axis_temp_data;
                            default: ;
                        endcase
                    end
                    if (w_pwr_hs) begin
                        r_power    <= s_axis_power_data;
                        r_pwr_held <= 1'b1;
                    end
                    r_cnt <= w_cnt_next;
                    if (w_temp_done && w_pwr_done) begin
                        r_state      <= S1;
                        r_temp_ready <= 1'b0;
                        r_pwr_ready  <= 1'b0;
                        r_cns        <= cns;
                        r_cwe        <= cwe;
                        r_cc         <= cc;
                        r_cap        <= Cap_1;
                        r_camb       <= c_amb;
                    end else begin
                        r_temp_ready <= (w_cnt_next < 3'd5);
                        r_pwr_ready  <= ~w_pwr_done;
                    end
                end
                S1: begin
                    r_acc   <= w_acc;
                    r_state <= S2;
                end
                S2: begin
                    r_out_data  <= w_res;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_row == 16'(CELLS_PER_ROW - 1));
                    r_state     <= OUT;
                end
                OUT: begin
                    if (m_axis_temp_ready) begin
                        r_out_valid  <= 1'b0;
                        r_out_last   <= 1'b0;
                        r_row        <= r_out_last ? '0 : r_row + 16'd1;
                        r_cnt        <= '0;
                        r_pwr_held   <= 1'b0;
                        r_temp_ready <= 1'b1;
                        r_pwr_ready  <= 1'b1;
                        r_state      <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign s_axis_temp_ready  = r_temp_ready;
    assign s_axis_power_ready = r_pwr_ready;
    assign m_axis_temp_data   = r_out_data;
    assign m_axis_temp_valid  = r_out_valid;
    assign m_axis_temp_last   = r_out_last;

endmodule

// File: tb/tb_hotspot_stencil_pipe.sv
// tb_hotspot_stencil_pipe
//   Directed bench for hotspot_stencil_pipe (Q10.22, CELLS_PER_ROW=4).
//   Expected results are hand-computed constants; the row position of each
//   result is tracked by the bench to predict m_axis_temp_last.
module tb_hotspot_stencil_pipe;

    logic        aclk = 1'b0;
    logic        axi_resetn;
    logic [31:0] s_axis_temp_data;
    logic        s_axis_temp_valid;
    logic        s_axis_temp_ready;
    logic [31:0] s_axis_power_data;
    logic        s_axis_power_valid;
    logic        s_axis_power_ready;
    logic [31:0] m_axis_temp_data;
    logic        m_axis_temp_valid;
    logic        m_axis_temp_ready;
    logic        m_axis_temp_last;
    logic [31:0] cns, cwe, cc, Cap_1, c_amb;

    int n_checks = 0;
    int n_errors = 0;
    int exp_row  = 0;

    always #5 aclk = ~aclk;

    hotspot_stencil_pipe #(
        .DATA_WIDTH    (32),
        .INT_WIDTH     (10),
        .FLOAT_WIDTH   (22),
        .CELLS_PER_ROW (4)
    ) u_dut (
        .aclk               (aclk),
        .axi_resetn         (axi_resetn),
        .s_axis_temp_data   (s_axis_temp_data),
        .s_axis_temp_valid  (s_axis_temp_valid),
        .s_axis_temp_ready  (s_axis_temp_ready),
        .s_axis_power_data  (s_axis_power_data),
        .s_axis_power_valid (s_axis_power_valid),
        .s_axis_power_ready (s_axis_power_ready),
        .m_axis_temp_data   (m_axis_temp_data),
        .m_axis_temp_valid  (m_axis_temp_valid),
        .m_axis_temp_ready  (m_axis_temp_ready),
        .m_axis_temp_last   (m_axis_temp_last),
        .cns                (cns),
        .cwe                (cwe),
        .cc                 (cc),
        .Cap_1              (Cap_1),
        .c_amb              (c_amb)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // mode 0: power with first temp beat; 1: power with last temp beat;
    // 2: temp beats with valid gaps, power after all temps.
    task automatic run_cell(input string tag, input logic [31:0] t [5],
                            input logic [31:0] pwr, input logic [31:0] k_ns,
                            input logic [31:0] k_we, input logic [31:0] k_c,
                            input logic [31:0] k_cap, input logic [31:0] k_amb,
                            input int mode, input int stall, input logic [31:0] exp);
        int unsigned ti = 0;
        int unsigned cyc = 0;
        int unsigned lat;
        bit pdone = 1'b0;
        bit hs_t, hs_p, pv;
        cns = k_ns; cwe = k_we; cc = k_c; Cap_1 = k_cap; c_amb = k_amb;
        while ((ti < 5 || !pdone) && cyc < 40) begin
            @(negedge aclk);
            s_axis_temp_valid = 1'b0;
            s_axis_temp_data  = 32'hDEADBEEF;
            if (ti < 5 && !(mode == 2 && cyc % 2 == 1)) begin
                s_axis_temp_valid = 1'b1;
                s_axis_temp_data  = t[ti];
            end
            pv = 1'b0;
            if (!pdone) begin
                case (mode)
                    0:       pv = 1'b1;
                    1:       pv = (ti == 4);
                    default: pv = (ti == 5);
                endcase
            end
            s_axis_power_valid = pv;
            s_axis_power_data  = pv ? pwr : 32'hBAD0BAD0;
            #1;
            hs_t = s_axis_temp_valid & s_axis_temp_ready;
            hs_p = s_axis_power_valid & s_axis_power_ready;
            @(posedge aclk);
            if (hs_t) ti++;
            if (hs_p) pdone = 1'b1;
            cyc++;
        end
        check_eq({tag, "_inputs_taken"}, 32'((ti == 5) && pdone), 32'd1);
        #1;
        s_axis_temp_valid  = 1'b0;
        s_axis_power_valid = 1'b0;
        check_eq({tag, "_busy_ready"}, {30'd0, s_axis_temp_ready, s_axis_power_ready}, 32'd0);
        lat = 1;
        while (!m_axis_temp_valid && lat < 10) begin
            @(posedge aclk);
            lat++;
            #1;
        end
        check_eq({tag, "_latency"}, lat, 32'd3);
        check_eq({tag, "_data"}, m_axis_temp_data, exp);
        check_eq({tag, "_last"}, {31'd0, m_axis_temp_last}, 32'(exp_row == 3));
        for (int unsigned k = 0; k < stall; k++) begin
            @(negedge aclk);
            s_axis_temp_valid  = 1'b1;
            s_axis_temp_data   = 32'h11111111;
            s_axis_power_valid = 1'b1;
            s_axis_power_data  = 32'h22222222;
            check_eq({tag, "_stall_hold"},
                     {m_axis_temp_data[29:0], m_axis_temp_valid, m_axis_temp_last},
                     {exp[29:0], 1'b1, exp_row == 3});
            check_eq({tag, "_stall_ready"}, {30'd0, s_axis_temp_ready, s_axis_power_ready}, 32'd0);
        end
        if (stall > 0) check_eq({tag, "_stall_data"}, m_axis_temp_data, exp);
        @(negedge aclk);
        s_axis_temp_valid  = 1'b0;
        s_axis_power_valid = 1'b0;
        m_axis_temp_ready  = 1'b1;
        @(posedge aclk);
        #1;
        m_axis_temp_ready = 1'b0;
        exp_row = (exp_row + 1) % 4;
        check_eq({tag, "_valid_drop"}, {31'd0, m_axis_temp_valid}, 32'd0);
        check_eq({tag, "_ready_back"}, {30'd0, s_axis_temp_ready, s_axis_power_ready}, 32'd3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_readys"}, {30'd0, s_axis_temp_ready, s_axis_power_ready}, 32'd0);
        check_eq({tag, "_valid_last"}, {30'd0, m_axis_temp_valid, m_axis_temp_last}, 32'd0);
        check_eq({tag, "_data"}, m_axis_temp_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] z5 [5];
        logic [31:0] sat_exp;
        z5 = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
`ifdef HOTSPOT_STENCIL_SAT_EN
        sat_exp = 32'h7FFFFFFF;
`else
        sat_exp = 32'h80400000;
`endif
        axi_resetn         = 1'b0;
        s_axis_temp_data   = '0;
        s_axis_temp_valid  = 1'b0;
        s_axis_power_data  = '0;
        s_axis_power_valid = 1'b0;
        m_axis_temp_ready  = 1'b0;
        cns = '0; cwe = '0; cc = '0; Cap_1 = '0; c_amb = '0;

        #1;
        check_reset_outputs("rst_t0");
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("rst_clk");
        @(negedge aclk);
        axi_resetn = 1'b1;
        #1;
        check_eq("rel_before_edge", {30'd0, s_axis_temp_ready, s_axis_power_ready}, 32'd0);
        @(posedge aclk);
        #1;
        check_eq("rel_first_edge", {30'd0, s_axis_temp_ready, s_axis_power_ready}, 32'd3);

        // Uniform 8.0 field: all differences zero, result equals c.
        run_cell("uniform8", '{32'h02000000, 32'h02000000, 32'h02000000, 32'h02000000, 32'h02000000},
                 32'h0, 32'h00123456, 32'hFFF00000, 32'h00400000, 32'h00800000, 32'h02000000,
                 0, 0, 32'h02000000);
        // Power only: 0 + 2.0*1.0.
        run_cell("power1", z5, 32'h00400000, 32'h00400000, 32'h00400000, 32'h00400000,
                 32'h00800000, 32'h0, 1, 0, 32'h00800000);
        // c=1,n=2,s=0,e=3,w=1,amb=0.5,p=0.25: acc=0+0.5-0.5+0.25, 1+2*0.25=1.5.
        run_cell("mixed", '{32'h00400000, 32'h00800000, 32'h0, 32'h00C00000, 32'h00400000},
                 32'h00100000, 32'h00200000, 32'h00100000, 32'h00400000, 32'h00800000,
                 32'h00200000, 2, 10, 32'h00600000);
        // amb=-1 LSB, cc=0.5: -2^-23 floors to -1 LSB.
        run_cell("floor", z5, 32'h0, 32'h0, 32'h0, 32'h00200000, 32'h00400000,
                 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF);
        // 511 + 2.0 overflows Q10.22.
        run_cell("overflow", '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000},
                 32'h00400000, 32'h00400000, 32'h00400000, 32'h00400000, 32'h00800000,
                 32'h7FC00000, 1, 0, sat_exp);

        // Reset with a partial cell (3 beats) held inside the block.
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge aclk);
            s_axis_temp_valid = 1'b1;
            s_axis_temp_data  = 32'h01000000 + k;
        end
        @(negedge aclk);
        s_axis_temp_valid = 1'b0;
        #2;
        axi_resetn = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        axi_resetn = 1'b1;
        exp_row = 0;
        @(posedge aclk);
        #1;
        check_eq("rel2_first_edge", {30'd0, s_axis_temp_ready, s_axis_power_ready}, 32'd3);

        for (int unsigned i = 0; i < 9; i++) begin
            run_cell($sformatf("row%0d", i + 1), z5, 32'h00400000, 32'h00400000, 32'h00400000,
                     32'h00400000, 32'h00800000, 32'h0, int'(i % 3), 0, 32'h00800000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
